// File: rtl/lsu_pkg.sv
// Shared types for the LSU memory requester: size codes, FSM states, lane masks.
// Optional misaligned split support is enabled by LSU_MISALIGNED_SPLIT_EN.
package lsu_pkg;

    localparam int LANES = 4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } lsu_size_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_ISSUE2 = 3'd3,
        ST_WAIT2  = 3'd4,
        ST_RESP   = 3'd5
    } lsu_state_e;

    // Base lane mask of an access before shifting by the byte offset.
    function automatic logic [LANES-1:0] size_mask(input logic [1:0] size);
        logic [LANES-1:0] m;
        m = '0;
        unique case (size)
            SZ_BYTE: m = 4'b0001;
            SZ_HALF: m = 4'b0011;
            SZ_WORD: m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load realignment: shifts the {hi, lo} word pair down by the byte offset
// and sign/zero-extends the selected byte, half or word.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [63:0] rdata_pair,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [31:0] field;

    // Select the addressed field and extend it to 32 bits.
    always_comb begin
        field  = 32'(rdata_pair >> {off, 3'b000});
        result = '0;
        unique case (size)
            SZ_BYTE: result = {{24{~is_unsigned & field[7]}}, field[7:0]};
            SZ_HALF: result = {{16{~is_unsigned & field[15]}}, field[15:0]};
            SZ_WORD: result = field;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_requester.sv
// Initiator for the single-port data memory macro: one load/store at a time.
// Define LSU_MISALIGNED_SPLIT_EN to split misaligned accesses into two beats.
module lsu_mem_requester
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clka,
    input  logic                  rsta_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [LANES-1:0]      mem_byte_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int WW = ADDR_WIDTH - 2;

    lsu_state_e state_q, state_d;

    logic                  we_q, we_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] lo_q, lo_d;
    logic [DATA_WIDTH-1:0] hi_q, hi_d;
    logic                  err_q, err_d;

    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  mem_en_q, mem_en_d;
    logic                  mem_we_q, mem_we_d;
    logic [LANES-1:0]      mem_byte_en_q, mem_byte_en_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    logic                  fire;
    logic [7:0]            req_mask8;
    logic                  req_mis;
    logic [7:0]            mask8;
    logic [2*DATA_WIDTH-1:0] wide;
    logic [WW-1:0]         word_d, word_inc;
    logic                  issue, beat1;
    logic [31:0]           align_out;
`ifdef LSU_MISALIGNED_SPLIT_EN
    logic [7:0]            q_mask8;
    logic                  split_q;
`endif

    assign fire      = req_valid & req_ready_q;
    assign req_mask8 = {4'b0000, size_mask(req_size)} << req_addr[1:0];
    assign req_mis   = |req_mask8[7:4];

`ifdef LSU_MISALIGNED_SPLIT_EN
    assign q_mask8 = {4'b0000, size_mask(size_q)} << addr_q[1:0];
    assign split_q = |q_mask8[7:4];
`endif

    // Next-state and request capture for the access sequencer.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (fire) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
`ifdef LSU_MISALIGNED_SPLIT_EN
                    err_d   = (req_size == SZ_ILL);
`else
                    err_d   = (req_size == SZ_ILL) | req_mis;
`endif
                    state_d = err_d ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!we_q) begin
                    state_d = ST_WAIT;
                end else begin
`ifdef LSU_MISALIGNED_SPLIT_EN
                    state_d = split_q ? ST_ISSUE2 : ST_RESP;
`else
                    state_d = ST_RESP;
`endif
                end
            end
            ST_WAIT: begin
                lo_d = mem_rdata;
`ifdef LSU_MISALIGNED_SPLIT_EN
                state_d = split_q ? ST_ISSUE2 : ST_RESP;
`else
                state_d = ST_RESP;
`endif
            end
`ifdef LSU_MISALIGNED_SPLIT_EN
            ST_ISSUE2: begin
                state_d = we_q ? ST_RESP : ST_WAIT2;
            end
            ST_WAIT2: begin
                hi_d    = mem_rdata;
                state_d = ST_RESP;
            end
`endif
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mask8    = {4'b0000, size_mask(size_d)} << addr_d[1:0];
    assign wide     = {{DATA_WIDTH{1'b0}}, wdata_d} << {addr_d[1:0], 3'b000};
    assign word_d   = addr_d[ADDR_WIDTH-1:2];
    assign word_inc = word_d + {{(WW-1){1'b0}}, 1'b1};

    lsu_load_align u_align (
        .rdata_pair  ({hi_d, lo_d}),
        .off         (addr_d[1:0]),
        .size        (size_d),
        .is_unsigned (uns_d),
        .result      (align_out)
    );

    // Registered outputs derived from the state being entered.
    always_comb begin
        issue         = (state_d == ST_ISSUE) | (state_d == ST_ISSUE2);
        beat1         = (state_d == ST_ISSUE2);
        req_ready_d   = (state_d == ST_IDLE);
        rsp_valid_d   = (state_d == ST_RESP);
        mem_en_d      = issue;
        mem_we_d      = issue & we_d;
        mem_addr_d    = '0;
        mem_byte_en_d = '0;
        mem_wdata_d   = '0;
        rsp_rdata_d   = '0;
        if (issue) begin
            mem_addr_d    = {beat1 ? word_inc : word_d, 2'b00};
            mem_byte_en_d = 4'hF;
            if (we_d) begin
                mem_byte_en_d = beat1 ? mask8[7:4] : mask8[3:0];
                mem_wdata_d   = beat1 ? wide[2*DATA_WIDTH-1:DATA_WIDTH]
                                      : wide[DATA_WIDTH-1:0];
            end
        end
        if (rsp_valid_d && !we_d && !err_d) begin
            rsp_rdata_d = align_out;
        end
    end

    // FSM state, captured request and output registers.
    always_ff @(posedge clka) begin
        if (!rsta_n) begin
            state_q       <= ST_IDLE;
            we_q          <= 1'b0;
            size_q        <= 2'b00;
            uns_q         <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            lo_q          <= '0;
            hi_q          <= '0;
            err_q         <= 1'b0;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_byte_en_q <= '0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            we_q          <= we_d;
            size_q        <= size_d;
            uns_q         <= uns_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            lo_q          <= lo_d;
            hi_q          <= hi_d;
            err_q         <= err_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            mem_en_q      <= mem_en_d;
            mem_we_q      <= mem_we_d;
            mem_byte_en_q <= mem_byte_en_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = err_q & rsp_valid_q;
    assign mem_en      = mem_en_q;
    assign mem_we      = mem_we_q;
    assign mem_byte_en = mem_byte_en_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_requester.sv
// Directed bench for lsu_mem_requester with a behavioural 1-cycle memory.
// Expectations follow the LSU_MISALIGNED_SPLIT_EN setting of the build.
module tb_lsu_mem_requester;

    logic        clka;
    logic        rsta_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    lsu_mem_requester #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clka         (clka),
        .rsta_n       (rsta_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_byte_en  (mem_byte_en),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    int n_cmp = 0;
    int n_bad = 0;

    // Small memory model: word index from address bits [7:2].
    logic [31:0] mem [64];
    logic [31:0] wl_addr [8];
    logic [3:0]  wl_be   [8];
    logic [31:0] wl_data [8];
    int          wcnt = 0;
    int          pulses = 0;

    always @(posedge clka) begin
        if (rsp_valid) pulses <= pulses + 1;
        if (mem_en) begin
            if (mem_we) begin
                for (int i = 0; i < 4; i++)
                    if (mem_byte_en[i])
                        mem[mem_addr[7:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
                wl_addr[wcnt % 8] <= mem_addr;
                wl_be[wcnt % 8]   <= mem_byte_en;
                wl_data[wcnt % 8] <= mem_wdata;
                wcnt <= wcnt + 1;
            end else begin
                mem_rdata <= mem[mem_addr[7:2]];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_beats;
        logic [31:0] wa0, wa1;
        logic [3:0]  wb0, wb1;
        logic [31:0] wd0, wd1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string nm, logic we, logic [1:0] sz,
                                logic uns, logic [31:0] a, logic [31:0] wd,
                                logic [31:0] er, logic ee, int lat, int bts);
        vec_t v;
        v.name = nm; v.we = we; v.size = sz; v.uns = uns;
        v.addr = a; v.wdata = wd; v.exp_rdata = er; v.exp_err = ee;
        v.exp_lat = lat; v.exp_beats = bts;
        v.wa0 = 0; v.wa1 = 0; v.wb0 = 0; v.wb1 = 0; v.wd0 = 0; v.wd1 = 0;
        return v;
    endfunction

    task automatic wait_ready();
        int g;
        g = 0;
        @(negedge clka);
        while (!req_ready && g < 20) begin
            @(negedge clka);
            g++;
        end
        if (!req_ready) chk("ready_timeout", {31'b0, req_ready}, 32'd1);
    endtask

    task automatic run_vec(input vec_t t);
        int lat, beats, wb;
        logic got;
        wait_ready();
        wb = wcnt;
        req_valid    = 1'b1;
        req_we       = t.we;
        req_size     = t.size;
        req_unsigned = t.uns;
        req_addr     = t.addr;
        req_wdata    = t.wdata;
        @(posedge clka);
        #1;
        req_valid = 1'b0;
        lat = 1; beats = 0; got = 1'b0;
        while (lat <= 12) begin
            if (mem_en) beats++;
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            @(posedge clka);
            #1;
            lat++;
        end
        chk({t.name, " rsp_seen"}, {31'b0, got}, 32'd1);
        chk({t.name, " latency"}, lat, t.exp_lat);
        chk({t.name, " rdata"}, rsp_rdata, t.exp_rdata);
        chk({t.name, " err"}, {31'b0, rsp_err}, {31'b0, t.exp_err});
        chk({t.name, " beats"}, beats, t.exp_beats);
        if (t.we && t.exp_beats >= 1) begin
            chk({t.name, " w0 addr"}, wl_addr[wb % 8], t.wa0);
            chk({t.name, " w0 be"}, {28'b0, wl_be[wb % 8]}, {28'b0, t.wb0});
            chk({t.name, " w0 data"}, wl_data[wb % 8], t.wd0);
        end
        if (t.we && t.exp_beats >= 2) begin
            chk({t.name, " w1 addr"}, wl_addr[(wb + 1) % 8], t.wa1);
            chk({t.name, " w1 be"}, {28'b0, wl_be[(wb + 1) % 8]}, {28'b0, t.wb1});
            chk({t.name, " w1 data"}, wl_data[(wb + 1) % 8], t.wd1);
        end
    endtask

    initial begin
        vec_t v;
        int p0;
        logic split;
`ifdef LSU_MISALIGNED_SPLIT_EN
        split = 1'b1;
`else
        split = 1'b0;
`endif
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[1] = 32'h03020100;
        mem[2] = 32'h07060504;
        mem[3] = 32'h000000F0;
        mem[4] = 32'h8899AABB;
        mem[8] = 32'h11223344;
        mem_rdata    = 32'h0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        rsta_n       = 1'b0;
        repeat (2) @(posedge clka);
        #1;
        chk("rst req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst mem_en", {31'b0, mem_en}, 32'd0);
        chk("rst mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst byte_en", {28'b0, mem_byte_en}, 32'd0);
        chk("rst rsp_rdata", rsp_rdata, 32'd0);
        chk("rst rsp_err", {31'b0, rsp_err}, 32'd0);
        @(negedge clka);
        rsta_n = 1'b1;

        vecs.push_back(mk("LB13", 0, 2'b00, 0, 32'h13, 0, 32'hFFFFFF88, 0, 3, 1));
        vecs.push_back(mk("LBU13", 0, 2'b00, 1, 32'h13, 0, 32'h00000088, 0, 3, 1));
        vecs.push_back(mk("LH12", 0, 2'b01, 0, 32'h12, 0, 32'hFFFF8899, 0, 3, 1));
        vecs.push_back(mk("LHU10", 0, 2'b01, 1, 32'h10, 0, 32'h0000AABB, 0, 3, 1));
        vecs.push_back(mk("LB11", 0, 2'b00, 0, 32'h11, 0, 32'hFFFFFFAA, 0, 3, 1));
        v = mk("SH22", 1, 2'b01, 0, 32'h22, 32'h0000BEEF, 0, 0, 2, 1);
        v.wa0 = 32'h20; v.wb0 = 4'b1100; v.wd0 = 32'hBEEF0000;
        vecs.push_back(v);
        vecs.push_back(mk("LW20a", 0, 2'b10, 0, 32'h20, 0, 32'hBEEF3344, 0, 3, 1));
        v = mk("SB21", 1, 2'b00, 0, 32'h21, 32'h0000005A, 0, 0, 2, 1);
        v.wa0 = 32'h20; v.wb0 = 4'b0010; v.wd0 = 32'h00005A00;
        vecs.push_back(v);
        vecs.push_back(mk("LW20b", 0, 2'b10, 0, 32'h20, 0, 32'hBEEF5A44, 0, 3, 1));
        vecs.push_back(mk("ILL_LD", 0, 2'b11, 0, 32'h10, 0, 0, 1, 1, 0));
        vecs.push_back(mk("ILL_ST", 1, 2'b11, 0, 32'h24, 32'h1234, 0, 1, 1, 0));
        if (split) begin
            vecs.push_back(mk("LW05", 0, 2'b10, 0, 32'h05, 0, 32'h04030201, 0, 5, 2));
            vecs.push_back(mk("LH0B", 0, 2'b01, 0, 32'h0B, 0, 32'hFFFFF007, 0, 5, 2));
            v = mk("SWwrap", 1, 2'b10, 0, 32'hFFFFFFFE, 32'hCAFEF00D, 0, 0, 3, 2);
            v.wa0 = 32'hFFFFFFFC; v.wb0 = 4'b1100; v.wd0 = 32'hF00D0000;
            v.wa1 = 32'h00000000; v.wb1 = 4'b0011; v.wd1 = 32'h0000CAFE;
            vecs.push_back(v);
            vecs.push_back(mk("LW00", 0, 2'b10, 0, 32'h0, 0, 32'h0000CAFE, 0, 3, 1));
            vecs.push_back(mk("LWFC", 0, 2'b10, 0, 32'hFFFFFFFC, 0, 32'hF00D0000, 0, 3, 1));
        end else begin
            vecs.push_back(mk("LW05", 0, 2'b10, 0, 32'h05, 0, 0, 1, 1, 0));
            vecs.push_back(mk("LH0B", 0, 2'b01, 0, 32'h0B, 0, 0, 1, 1, 0));
            vecs.push_back(mk("SWwrap", 1, 2'b10, 0, 32'hFFFFFFFE, 32'hCAFEF00D, 0, 1, 1, 0));
            vecs.push_back(mk("LW00", 0, 2'b10, 0, 32'h0, 0, 32'h0, 0, 3, 1));
            vecs.push_back(mk("LWFC", 0, 2'b10, 0, 32'hFFFFFFFC, 0, 32'h0, 0, 3, 1));
        end

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset while a load waits for its read data.
        wait_ready();
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10;
        req_unsigned = 1'b0; req_addr = 32'h10; req_wdata = 32'h0;
        @(posedge clka);
        #1;
        req_valid = 1'b0;
        chk("rw issue mem_en", {31'b0, mem_en}, 32'd1);
        @(posedge clka);
        #1;
        chk("rw wait mem_en", {31'b0, mem_en}, 32'd0);
        p0 = pulses;
        @(negedge clka);
        rsta_n = 1'b0;
        @(posedge clka);
        #1;
        chk("rw req_ready", {31'b0, req_ready}, 32'd1);
        chk("rw rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rw mem_en", {31'b0, mem_en}, 32'd0);
        @(negedge clka);
        rsta_n = 1'b1;
        repeat (4) @(posedge clka);
        #1;
        chk("rw no pulse", pulses, p0);
        chk("rw idle ready", {31'b0, req_ready}, 32'd1);

        // A normal load still completes after the abort.
        run_vec(mk("LB13post", 0, 2'b00, 0, 32'h13, 0, 32'hFFFFFF88, 0, 3, 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lsu_mem_requester.md
Name: lsu_mem_requester

Overview:
- Initiator side of the single-port data memory macro interface. Accepts one load/store at a time from the RV32 execute stage.
- Generates the aligned byte address, byte enables and lane-shifted write data, and drives the macro's enable/write strobes.
- Captures the 1-cycle-latency read data, then realigns and sign/zero-extends it.
- Returns a single-cycle response pulse to the pipeline.

Parameters:
- ADDR_WIDTH, 32, byte-address width presented to the memory (word index = addr >> 2).
- DATA_WIDTH, 32, data width; fixed at 32 (4 byte lanes).

Ports:
- clka  in  1  clock.
- rsta_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  pipeline request present.
- req_ready  out  1  request accepted this cycle (high only in IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extend (LBU/LHU).
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data (0 for stores/errors).
- rsp_err  out  1  misaligned or illegal-size access.
- mem_en  out  1  macro enable.
- mem_we  out  1  macro write enable.
- mem_byte_en  out  4  byte lane enables.
- mem_addr  out  ADDR_WIDTH  byte address, low 2 bits forced 0.
- mem_wdata  out  32  lane-shifted write data.
- mem_rdata  in  32  macro read data, valid the cycle after a read with mem_en=1.

Behaviour:
- Reset (rsta_n=0 at posedge): state IDLE. All outputs 0 except req_ready=1. Overrides any in-flight access.
- Accept: fire = req_valid & req_ready. Register we/size/unsigned/addr/wdata; off = addr[1:0].
- Masks and data: mask8 = {1,3,F}[size] << off (8-bit); wide = {32'b0, wdata} << 8*off (64-bit). Beat0 uses mask8[3:0]/wide[31:0]; beat1 uses mask8[7:4]/wide[63:32].
- Misaligned: half with off=3, or word with off≠0. Equivalently, mask8[7:4]≠0.
- FSM states: IDLE, ISSUE, WAIT, ISSUE2, WAIT2, RESP.
- IDLE:
  - On fire with size=11 or (misaligned and split not compiled in): go to RESP with rsp_err=1, rdata=0. No memory access.
  - Otherwise go to ISSUE.
- ISSUE: mem_en=1, mem_we=we, mem_addr = {addr[ADDR_WIDTH-1:2], 2'b00}, beat0 lanes. mem_byte_en = beat0 mask for stores, 4'hF for loads.
  - Load → WAIT.
  - Store → ISSUE2 if split needed, else RESP.
- WAIT: mem_en=0. Capture mem_rdata into lo. Split needed → ISSUE2, else RESP.
- ISSUE2: mem_addr = word index + 1, wrapping modulo 2^(ADDR_WIDTH-2); beat1 lanes.
  - Load → WAIT2; store → RESP.
- WAIT2: capture mem_rdata into hi → RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle.
  - Load: rsp_rdata = extend(({hi, lo} >> 8*off)[size bits]), with sign taken from the MSB of the selected field unless req_unsigned.
  - Store: rsp_rdata=0.
  - Next state IDLE. No response back-pressure.
- Latency, fire at edge T:
  - Aligned load: rsp_valid in cycle T+3.
  - Aligned store: write edge at end of ISSUE, rsp_valid in cycle T+2.
  - Split load: T+5. Split store: T+3.
- mem_en/mem_we are 0 in every state except ISSUE/ISSUE2. A write never coincides with a read capture.
- req_valid held while not ready: no effect. Only one outstanding access.

Optional Feature:
- Macro LSU_MISALIGNED_SPLIT_EN.
- Defined: misaligned accesses are split into two aligned beats using the ISSUE2/WAIT2 path and complete with rsp_err=0.
- Undefined: ISSUE2/WAIT2 are not synthesised. Misaligned accesses respond in RESP with rsp_err=1, rsp_rdata=0 and no memory traffic (rsp_valid at T+1).
- size=11 errors in both builds.

Decomposition:
- Package lsu_pkg:
  - Size encodings (SZ_BYTE/SZ_HALF/SZ_WORD).
  - FSM state encoding.
  - Lane count (4).
  - Mask lookup function (size → base mask).
- Sub-module lsu_load_align (combinational): {hi, lo}, off, size, unsigned → 32-bit extended result. Reused by a future store-buffer forwarding path.

Test Plan:
- Memory word 0x10 = 0x8899AABB. LB addr 0x13 → rsp_rdata 0xFFFFFF88, rsp_valid at T+3. LBU same → 0x00000088.
- SH addr 0x22 wdata 0x0000BEEF → mem_byte_en=1100, mem_wdata=0xBEEF0000, mem_addr=0x20. A following LW 0x20 returns 0xBEEFxxxx with the low half unchanged.
- LW addr 0x05:
  - Split build: two reads (0x04, 0x08) → rsp_rdata = {mem[0x08][7:0], mem[0x04][31:8]}, rsp_err=0.
  - Non-split build: rsp_err=1 at T+1, mem_en never high.
- SW addr 0x...FFFE (top of space), split build → second beat mem_addr=0x00000000, byte_en 0011. Wrap-around verified.
- req_size=11 → rsp_err=1, no mem_en.
- rsta_n low during WAIT → next cycle IDLE, rsp_valid never asserted, req_ready=1.
